// File: rtl/yutorina_bus_pkg.sv
// Shared constants and types for the on-chip bus arbiter slice.
package yutorina_bus_pkg;

    localparam int unsigned N_MASTERS_DEF = 4;
    localparam int unsigned MAX_HOLD_DEF  = 16;
    localparam int unsigned OWNER_W       = $clog2(N_MASTERS_DEF);

    typedef logic [OWNER_W-1:0]       owner_t;
    typedef logic [N_MASTERS_DEF-1:0] grant_t;

    localparam owner_t MASTER_IF     = OWNER_W'(0);
    localparam owner_t MASTER_MEM    = OWNER_W'(1);
    localparam owner_t MASTER_LOADER = OWNER_W'(2);
    localparam owner_t MASTER_DMA    = OWNER_W'(3);

endpackage

// File: rtl/yutorina_bus_arbiter_if.sv
// Request/grant bundle between bus masters and the arbiter.
interface yutorina_bus_arbiter_if
    import yutorina_bus_pkg::*;
#(
    parameter int unsigned N_MASTERS = N_MASTERS_DEF
);
    localparam int unsigned OW = $clog2(N_MASTERS);

    logic [N_MASTERS-1:0] req;
    logic                 xfer_done;
    logic [N_MASTERS-1:0] grnt;
    logic [OW-1:0]        owner;
    logic                 grant_chg;

    modport master (
        output req, xfer_done,
        input  grnt, owner, grant_chg
    );

    modport slave (
        input  req, xfer_done,
        output grnt, owner, grant_chg
    );
endinterface

// File: rtl/yutorina_rr_pick.sv
// Round-robin winner search: rotate so start_i is bit 0, find first set, unrotate.
module yutorina_rr_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]         req_i,
    input  logic [$clog2(N)-1:0] start_i,
    input  logic                 excl_i,
    output logic [$clog2(N)-1:0] win_idx_c_o,
    output logic                 found_c_o
);
    localparam int unsigned IW = $clog2(N);

    logic [N-1:0]  masked;
    logic [N-1:0]  rot;
    logic [IW-1:0] off;

    always_comb begin
        masked = req_i;
        // The bit just below the start position is the current owner.
        if (excl_i) masked[IW'(start_i - IW'(1))] = 1'b0;
        rot       = N'({masked, masked} >> start_i);
        found_c_o = 1'b0;
        off       = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found_c_o = 1'b1;
                off       = IW'(i);
            end
        end
        win_idx_c_o = IW'(start_i + off);
    end
endmodule

// File: rtl/yutorina_bus_arbiter.sv
// Round-robin bus arbiter with bounded hold time; hands over only on transfer boundaries.
module yutorina_bus_arbiter
    import yutorina_bus_pkg::*;
#(
    parameter int unsigned N_MASTERS = N_MASTERS_DEF,
    parameter int unsigned MAX_HOLD  = MAX_HOLD_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    yutorina_bus_arbiter_if.slave  bus
);
    localparam int unsigned OW = $clog2(N_MASTERS);
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam logic [HW-1:0]        HOLD_SAT  = HW'(MAX_HOLD - 1);
    localparam logic [N_MASTERS-1:0] GRNT_RST  = N_MASTERS'(1) << MASTER_IF;

    logic [OW-1:0]        owner_q, owner_d;
    logic [N_MASTERS-1:0] grnt_q, grnt_d;
    logic [HW-1:0]        hold_q, hold_d;
    logic                 chg_q, chg_d;

    logic [OW-1:0] start_c;
    logic [OW-1:0] win_c;
    logic          found_c;
    logic          owner_req_c;
    logic          others_c;
    logic          release_c;
    logic          force_c;

    assign start_c = OW'(owner_q + OW'(1));

    yutorina_rr_pick #(.N(N_MASTERS)) u_pick (
        .req_i       (bus.req),
        .start_i     (start_c),
        .excl_i      (1'b1),
        .win_idx_c_o (win_c),
        .found_c_o   (found_c)
    );

    assign owner_req_c = bus.req[owner_q];
    assign others_c    = |(bus.req & ~grnt_q);
    assign release_c   = !owner_req_c && others_c;
    assign force_c     = owner_req_c && (hold_q == HOLD_SAT) && bus.xfer_done && others_c;

    // Next owner, hold counter and change pulse.
    always_comb begin
        owner_d = owner_q;
        grnt_d  = grnt_q;
        hold_d  = hold_q;
        chg_d   = 1'b0;
        if ((release_c || force_c) && found_c) begin
            owner_d = win_c;
            grnt_d  = N_MASTERS'(1) << win_c;
            hold_d  = '0;
            chg_d   = 1'b1;
        end else if (!owner_req_c) begin
            hold_d = '0;
        end else if (hold_q != HOLD_SAT) begin
            hold_d = HW'(hold_q + HW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q <= OW'(MASTER_IF);
            grnt_q  <= GRNT_RST;
            hold_q  <= '0;
            chg_q   <= 1'b0;
        end else begin
            owner_q <= owner_d;
            grnt_q  <= grnt_d;
            hold_q  <= hold_d;
            chg_q   <= chg_d;
        end
    end

    assign bus.grnt      = grnt_q;
    assign bus.owner     = owner_q;
    assign bus.grant_chg = chg_q;
endmodule

// File: tb/tb_yutorina_bus_arbiter.sv
// Self-checking bench: vector table plus scenario sequences, expectations queued per cycle.
module tb_yutorina_bus_arbiter;
    import yutorina_bus_pkg::*;

    logic clk;
    logic rst;

    yutorina_bus_arbiter_if #(.N_MASTERS(N_MASTERS_DEF)) bus ();

    yutorina_bus_arbiter #(
        .N_MASTERS (N_MASTERS_DEF),
        .MAX_HOLD  (MAX_HOLD_DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        grant_t g;
        logic   c;
    } exp_t;

    typedef struct packed {
        logic   rst;
        grant_t req;
        logic   xd;
        grant_t g;
        logic   c;
    } vec_t;

    exp_t sb_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    function automatic owner_t idx_of(input grant_t g);
        owner_t r = '0;
        for (int i = 0; i < N_MASTERS_DEF; i++)
            if (g[i]) r = OWNER_W'(i);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // Drive one cycle, queue what must appear after the edge, then compare.
    task automatic cyc(input logic r, input grant_t rq, input logic xd,
                       input grant_t eg, input logic ec, input string nm);
        exp_t e;
        rst           = r;
        bus.req       = rq;
        bus.xfer_done = xd;
        sb_q.push_back('{g: eg, c: ec});
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        chk({nm, ".grnt"},  32'(bus.grnt),      32'(e.g));
        chk({nm, ".owner"}, 32'(bus.owner),     32'(idx_of(e.g)));
        chk({nm, ".chg"},   32'(bus.grant_chg), 32'(e.c));
        chk({nm, ".onehot"}, 32'($onehot(bus.grnt)), 32'(1));
    endtask

    vec_t tbl[16];

    initial begin
        rst           = 1'b1;
        bus.req       = 4'b1111;
        bus.xfer_done = 1'b0;

        // Reset held two cycles with everyone requesting.
        cyc(1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, "reset0");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, "reset1");

        // Fairness: continuous requests, transfer boundary every cycle.
        for (int e = 0; e < 80; e++)
            cyc(1'b0, 4'b1111, 1'b1, grant_t'(4'b0001 << (((e + 1) / 16) % 4)),
                ((e + 1) % 16) == 0, "fair");

        tbl[0]  = '{rst: 1'b1, req: 4'b0000, xd: 1'b0, g: 4'b0001, c: 1'b0};
        tbl[1]  = '{rst: 1'b0, req: 4'b1010, xd: 1'b0, g: 4'b0010, c: 1'b1};
        tbl[2]  = '{rst: 1'b0, req: 4'b1010, xd: 1'b0, g: 4'b0010, c: 1'b0};
        tbl[3]  = '{rst: 1'b0, req: 4'b1000, xd: 1'b0, g: 4'b1000, c: 1'b1};
        tbl[4]  = '{rst: 1'b0, req: 4'b1000, xd: 1'b1, g: 4'b1000, c: 1'b0};
        tbl[5]  = '{rst: 1'b0, req: 4'b0000, xd: 1'b0, g: 4'b1000, c: 1'b0};
        tbl[6]  = '{rst: 1'b0, req: 4'b0000, xd: 1'b1, g: 4'b1000, c: 1'b0};
        tbl[7]  = '{rst: 1'b0, req: 4'b0001, xd: 1'b0, g: 4'b0001, c: 1'b1};
        tbl[8]  = '{rst: 1'b0, req: 4'b0001, xd: 1'b0, g: 4'b0001, c: 1'b0};
        tbl[9]  = '{rst: 1'b0, req: 4'b0110, xd: 1'b0, g: 4'b0010, c: 1'b1};
        tbl[10] = '{rst: 1'b0, req: 4'b0100, xd: 1'b0, g: 4'b0100, c: 1'b1};
        tbl[11] = '{rst: 1'b0, req: 4'b0101, xd: 1'b0, g: 4'b0100, c: 1'b0};
        tbl[12] = '{rst: 1'b0, req: 4'b0001, xd: 1'b0, g: 4'b0001, c: 1'b1};
        tbl[13] = '{rst: 1'b0, req: 4'b0011, xd: 1'b0, g: 4'b0001, c: 1'b0};
        tbl[14] = '{rst: 1'b0, req: 4'b1010, xd: 1'b0, g: 4'b0010, c: 1'b1};
        tbl[15] = '{rst: 1'b0, req: 4'b1101, xd: 1'b0, g: 4'b0100, c: 1'b1};
        for (int i = 0; i < 16; i++)
            cyc(tbl[i].rst, tbl[i].req, tbl[i].xd, tbl[i].g, tbl[i].c, $sformatf("vec%0d", i));

        // Forced handover: master 1 holds, master 2 waits, boundary every 4th cycle.
        cyc(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, "force_rst");
        cyc(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, "force_take");
        for (int e = 1; e <= 20; e++)
            cyc(1'b0, 4'b0110, (e % 4) == 0, (e >= 16) ? 4'b0100 : 4'b0010,
                e == 16, $sformatf("force%0d", e));

        // Saturated counter without a transfer boundary never hands over.
        cyc(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, "block_rst");
        cyc(1'b0, 4'b0010, 1'b0, 4'b0010, 1'b1, "block_take");
        for (int e = 1; e <= 40; e++)
            cyc(1'b0, 4'b0110, 1'b0, 4'b0010, 1'b0, "block");

        // Reset while master 2 has been holding for a while.
        cyc(1'b1, 4'b0000, 1'b0, 4'b0001, 1'b0, "midrst_rst");
        cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b1, "midrst_take");
        for (int e = 1; e <= 9; e++)
            cyc(1'b0, 4'b0100, 1'b0, 4'b0100, 1'b0, "midrst_hold");
        cyc(1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, "midrst_reset");
        for (int k = 0; k < 20; k++)
            cyc(1'b0, 4'b0101, 1'b1, ((k + 1) >= 16) ? 4'b0100 : 4'b0001,
                (k + 1) == 16, "midrst_after");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
